// File: rtl/md5_padder.sv
// MD5 message padder: packs 32-bit little-endian words into 512-bit blocks,
// appends the 0x80 marker, zero fill and the 64-bit bit length.
//   state     | meaning
//   FILL      | accepting message words into the block register
//   EMIT      | data block presented, waiting for blk_ready
//   TAIL      | building the extra padding-only block
//   EMIT_TAIL | padding-only block presented, waiting for blk_ready
module md5_padder #(
    parameter int LEN_W = 64
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic [2:0]   in_bytes,
    input  logic         in_last,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_last
);

    typedef enum logic [1:0] {FILL, EMIT, TAIL, EMIT_TAIL} state_t;

    state_t           state;
    logic [3:0]       wptr;
    logic [LEN_W-1:0] bitcnt;
    logic             tail_pending;
    logic             marker_pending;
    logic             mid_msg;

    logic [2:0]       nbytes;
    logic [LEN_W-1:0] bitcnt_nxt;
    logic [6:0]       word_base;
    logic [6:0]       mark_pos;
    logic [511:0]     blk_fill;
    logic             accept;

    assign in_ready   = (state == FILL);
    assign accept     = in_valid & in_ready;
    assign word_base  = {1'b0, wptr, 2'b00};
    assign mark_pos   = word_base + 7'(nbytes);
    assign bitcnt_nxt = bitcnt + LEN_W'({nbytes, 3'b000});

    always_comb begin
        nbytes = 3'd4;
        if (in_last && in_bytes < 3'd4)
            nbytes = in_bytes;
    end

    // Final word: bytes below the marker keep data, marker at mark_pos, zeros above.
    always_comb begin
        blk_fill = blk_data;
        if (!in_last) begin
            blk_fill[32*wptr +: 32] = in_data;
        end else begin
            for (int b = 0; b < 64; b++) begin
                if (7'(b) >= word_base) begin
                    if (7'(b) < mark_pos)
                        blk_fill[8*b +: 8] = in_data[8*(b%4) +: 8];
                    else if (7'(b) == mark_pos)
                        blk_fill[8*b +: 8] = 8'h80;
                    else
                        blk_fill[8*b +: 8] = 8'h00;
                end
            end
            if (mark_pos <= 7'd55) begin
                blk_fill[448 +: 32] = bitcnt_nxt[31:0];
                blk_fill[480 +: 32] = bitcnt_nxt[63:32];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state          <= FILL;
            wptr           <= '0;
            bitcnt         <= '0;
            tail_pending   <= 1'b0;
            marker_pending <= 1'b0;
            mid_msg        <= 1'b0;
            blk_data       <= '0;
            blk_valid      <= 1'b0;
            blk_first      <= 1'b0;
            blk_last       <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        bitcnt   <= bitcnt_nxt;
                        blk_data <= blk_fill;
                        if (in_last) begin
                            blk_valid      <= 1'b1;
                            blk_first      <= ~mid_msg;
                            blk_last       <= (mark_pos <= 7'd55);
                            tail_pending   <= (mark_pos > 7'd55);
                            marker_pending <= (mark_pos == 7'd64);
                            state          <= EMIT;
                        end else if (wptr == 4'd15) begin
                            blk_valid <= 1'b1;
                            blk_first <= ~mid_msg;
                            blk_last  <= 1'b0;
                            state     <= EMIT;
                        end else begin
                            wptr <= wptr + 4'd1;
                        end
                    end
                end
                EMIT: begin
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        mid_msg   <= ~blk_last;
                        if (tail_pending) begin
                            state <= TAIL;
                        end else begin
                            blk_data <= '0;
                            wptr     <= '0;
                            // a length-bearing block ends the message
                            if (blk_last)
                                bitcnt <= '0;
                            state    <= FILL;
                        end
                    end
                end
                TAIL: begin
                    blk_data  <= {bitcnt, 448'(marker_pending ? 8'h80 : 8'h00)};
                    blk_last  <= 1'b1;
                    blk_first <= ~mid_msg;
                    blk_valid <= 1'b1;
                    state     <= EMIT_TAIL;
                end
                EMIT_TAIL: begin
                    if (blk_ready) begin
                        blk_valid      <= 1'b0;
                        bitcnt         <= '0;
                        wptr           <= '0;
                        tail_pending   <= 1'b0;
                        marker_pending <= 1'b0;
                        mid_msg        <= 1'b0;
                        blk_data       <= '0;
                        state          <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
